// File: rtl/reg_file_wb_pkg.sv
// reg_file_wb_pkg: shared sizes and write-port types for the writeback register file.
package reg_file_wb_pkg;
    localparam int REG_W  = 8;
    localparam int REG_N  = 8;
    localparam int REG_AW = $clog2(REG_N);

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic             we;
        reg_addr_t        addr;
        logic [REG_W-1:0] data;
    } regfile_wr_t;
endpackage

// File: rtl/reg_file_wb_load_scoreboard.sv
// load_scoreboard: per-register pending-load bits with issue-over-return priority.
module load_scoreboard
    import reg_file_wb_pkg::*;
#(
    parameter int NREGS = REG_N,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic [AW-1:0] issue_addr,
    input  logic          ret,
    input  logic [AW-1:0] ret_addr,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic          pend_a,
    output logic          pend_b
);
    logic [NREGS-1:0] pending, set, clr, pend_eff;

    always_comb begin
        set = '0;
        clr = '0;
        set[issue_addr] = issue;
        clr[ret_addr] = ret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= set | (pending & ~clr);
    end

    // A returning load feeds its operand through the bypass, so it no longer stalls.
    assign pend_eff = pending & ~clr;
    assign pend_a   = pend_eff[addr_a];
    assign pend_b   = pend_eff[addr_b];
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: two-read register file with write bypass, Zero flag and load scoreboard.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int W     = REG_W,
    parameter int NREGS = REG_N,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en_a,
    input  logic [AW-1:0] rd_addr_a,
    output logic [W-1:0]  rd_data_a,
    input  logic          rd_en_b,
    input  logic [AW-1:0] rd_addr_b,
    output logic [W-1:0]  rd_data_b,
    input  logic          alu_we,
    input  logic [AW-1:0] alu_waddr,
    input  logic [W-1:0]  alu_wdata,
    input  logic          flag_we,
    input  logic          alu_zero,
    output logic          zero_flag,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_waddr,
    input  logic          ld_ret,
    input  logic [AW-1:0] ld_raddr,
    input  logic [W-1:0]  ld_rdata,
    output logic          stall
);
    logic [W-1:0] regs [NREGS];
    regfile_wr_t  alu_wr, ld_wr;
    logic         pend_a, pend_b;

    assign alu_wr = '{we: alu_we, addr: alu_waddr, data: alu_wdata};
    assign ld_wr  = '{we: ld_ret, addr: ld_raddr, data: ld_rdata};

    // Load write is issued last so it overrides an ALU write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            zero_flag <= 1'b0;
        end else begin
            if (alu_wr.we) regs[alu_wr.addr] <= alu_wr.data;
            if (ld_wr.we) regs[ld_wr.addr] <= ld_wr.data;
            if (flag_we) zero_flag <= alu_zero;
        end
    end

    always_comb begin
        rd_data_a = (ld_wr.we && ld_wr.addr == rd_addr_a) ? ld_wr.data :
                    (alu_wr.we && alu_wr.addr == rd_addr_a) ? alu_wr.data : regs[rd_addr_a];
        rd_data_b = (ld_wr.we && ld_wr.addr == rd_addr_b) ? ld_wr.data :
                    (alu_wr.we && alu_wr.addr == rd_addr_b) ? alu_wr.data : regs[rd_addr_b];
    end

    load_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (ld_issue),
        .issue_addr (ld_waddr),
        .ret        (ld_ret),
        .ret_addr   (ld_raddr),
        .addr_a     (rd_addr_a),
        .addr_b     (rd_addr_b),
        .pend_a     (pend_a),
        .pend_b     (pend_b)
    );

    assign stall = (rd_en_a & pend_a) | (rd_en_b & pend_b);
endmodule
